// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter that lets several message sources share one byte-wide uart.
// The granted buffer is latched and streamed MSB-byte-first, at most one byte every two cycles.
module uart_msg_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BYTES = 37,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]         req_len,
  input  logic [NUM_REQ-1:0][MAX_BYTES*8-1:0]   req_msg,
  output logic [NUM_REQ-1:0]                    grant,
  output logic [NUM_REQ-1:0]                    done,
  output logic                                  busy,
  output logic [7:0]                            data,
  output logic                                  data_valid,
  input  logic                                  uart_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MSG_W = MAX_BYTES * 8;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]     sel_reg, sel_next;
  logic [IDX_W-1:0]     rr_reg, rr_next;
  logic [MSG_W-1:0]     buf_reg, buf_next;
  logic [LEN_W-1:0]     cnt_reg, cnt_next;
  logic [7:0]           data_reg, data_next;
  logic                 dv_reg, dv_next;

  logic [IDX_W-1:0]     pick;
  logic [LEN_W-1:0]     pick_len;
  logic [LEN_W-1:0]     pick_cnt;

  // Walk from the source just after the last winner; the lowest offset that is requesting wins.
  always_comb begin
    int cand;
    pick = '0;
    cand = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = int'(rr_reg) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[IDX_W'(cand)]) pick = IDX_W'(cand);
    end
  end

  assign pick_len = req_len[pick];
  assign pick_cnt = (pick_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : pick_len;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    sel_next   = sel_reg;
    rr_next    = rr_reg;
    buf_next   = buf_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    dv_next    = dv_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          sel_next   = pick;
          grant_next = NUM_REQ'(1) << pick;
          buf_next   = req_msg[pick];
          cnt_next   = pick_cnt;
          state_next = (pick_cnt == '0) ? ST_DONE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (uart_ready) begin
          data_next  = buf_reg[MSG_W-1 -: 8];
          dv_next    = 1'b1;
          buf_next   = buf_reg << 8;
          cnt_next   = cnt_reg - LEN_W'(1);
          state_next = ST_GAP;
        end
      end
      // The uart only drops ready one cycle after a strobe, so ready is ignored here.
      ST_GAP: begin
        dv_next    = 1'b0;
        state_next = (cnt_reg == '0) ? ST_DONE : ST_SEND;
      end
      ST_DONE: begin
        grant_next = '0;
        rr_next    = sel_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      sel_reg   <= '0;
      rr_reg    <= IDX_W'(NUM_REQ - 1);
      buf_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      dv_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      sel_reg   <= sel_next;
      rr_reg    <= rr_next;
      buf_reg   <= buf_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      dv_reg    <= dv_next;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_done
    assign done[gi] = grant_reg[gi] & (state_reg == ST_DONE);
  end

  assign grant      = grant_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign data       = data_reg;
  assign data_valid = dv_reg;

endmodule
